// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the alu and its round-robin arbiter.
//   ALU_SEL_W   - width of the alu operation select
//   ALU_WIDTH   - alu data width
//   arb_state_e - arbiter sequencer states (2-bit binary encoding)
package alu_pkg;

  localparam int ALU_SEL_W = 2;
  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

endpackage : alu_pkg

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin priority picker.
//   req    [NREQ]   - request vector
//   ptr    [PTR_W]  - index of the highest-priority requester (must be < NREQ)
//   onehot [NREQ]   - one-hot winner, all zero when no request
//   idx    [PTR_W]  - binary index of the winner, 0 when no request
//   any             - at least one request is pending
module rr_picker #(
  parameter int NREQ  = 2,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int slot;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    slot   = 0;
    // Walk the requesters starting at ptr, wrapping at NREQ; the first hit wins.
    for (int k = 0; k < NREQ; k++) begin
      slot = int'(ptr) + k;
      if (slot >= NREQ) slot = slot - NREQ;
      if (!any && req[slot]) begin
        any          = 1'b1;
        idx          = PTR_W'(slot);
        onehot[slot] = 1'b1;
      end
    end
  end

endmodule : rr_picker

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one combinational alu
// between NREQ requesters. The winner's operands are latched into the alu
// input registers, the alu runs for one full cycle, its output is registered
// into result and a one-hot done pulse tells the owner its result is ready.
// One operation per three cycles: IDLE (arbitrate) -> EXEC -> DONE.
//   clk, rst            - clock, synchronous active-high reset
//   req                 - level requests, held with operands until done[i]
//   data1_in, data2_in  - packed operands, requester i at [i*WIDTH +: WIDTH]
//   sel_in              - packed alu selects, requester i at [i*2 +: 2]
//   grant, done         - registered one-hot owner / one-cycle result strobe
//   result              - registered alu result, held until the next done
//   busy                - high in EXEC and DONE
//   alu_data1/2, alu_sel, alu_out - registered interface to the shared alu
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WIDTH-1:0]      data1_in,
  input  logic [NREQ*WIDTH-1:0]      data2_in,
  input  logic [NREQ*ALU_SEL_W-1:0]  sel_in,
  output logic [NREQ-1:0]            grant,
  output logic [NREQ-1:0]            done,
  output logic [WIDTH-1:0]           result,
  output logic                       busy,
  output logic [WIDTH-1:0]           alu_data1,
  output logic [WIDTH-1:0]           alu_data2,
  output logic [ALU_SEL_W-1:0]       alu_sel,
  input  logic [WIDTH-1:0]           alu_out
);

  localparam int PTR_W = $clog2(NREQ);

  arb_state_e           state, next_state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     winner;
  logic [NREQ-1:0]      pick_onehot;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [WIDTH-1:0]     win_data1;
  logic [WIDTH-1:0]     win_data2;
  logic [ALU_SEL_W-1:0] win_sel;
  logic [PTR_W-1:0]     ptr_after_winner;

  rr_picker #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Operand mux steered by the one-hot winner.
  always_comb begin
    win_data1 = '0;
    win_data2 = '0;
    win_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_onehot[i]) begin
        win_data1 = data1_in[i*WIDTH +: WIDTH];
        win_data2 = data2_in[i*WIDTH +: WIDTH];
        win_sel   = sel_in[i*ALU_SEL_W +: ALU_SEL_W];
      end
    end
  end

  // The requester just served drops to lowest priority.
  assign ptr_after_winner = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (pick_any) next_state = ST_EXEC;
      ST_EXEC: next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant     <= '0;
      done      <= '0;
      result    <= '0;
      alu_data1 <= '0;
      alu_data2 <= '0;
      alu_sel   <= '0;
      ptr       <= '0;
      winner    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant     <= pick_onehot;
            winner    <= pick_idx;
            alu_data1 <= win_data1;
            alu_data2 <= win_data2;
            alu_sel   <= win_sel;
          end
        end
        ST_EXEC: begin
          result <= alu_out;
          done   <= grant;
        end
        ST_DONE: begin
          // alu_* keep their last values; only ownership is released.
          ptr   <= ptr_after_winner;
          grant <= '0;
          done  <= '0;
        end
        default: begin
          grant <= '0;
          done  <= '0;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule : alu_arbiter

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single combinational 32-bit alu (data1, data2, sel[1:0] -> out) between NREQ requesters, such as the fetch-side PC adder and the execute stage.
- Latches the winning requester's operands, drives the shared alu for one full cycle, registers alu out, and returns the result with a one-hot done pulse.
- Sits between the requesting stages and the alu instance. The alu itself is outside this block.

Parameters:
NREQ, 2, number of requesters (2..8)
WIDTH, 32, operand/result width; must match the alu data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req  in  NREQ  level request; requester i holds it and its operands stable until done[i]
data1_in  in  NREQ*WIDTH  operand 1 of requester i at [i*WIDTH +: WIDTH]
data2_in  in  NREQ*WIDTH  operand 2 of requester i, same packing
sel_in  in  NREQ*2  alu op select of requester i at [i*2 +: 2]; passed through unchanged
grant  out  NREQ  one-hot owner of the alu, registered
done  out  NREQ  one-hot, one-cycle pulse: result valid for that requester
result  out  WIDTH  registered alu result; held until the next done
busy  out  1  high in EXEC and DONE
alu_data1  out  WIDTH  to alu data1, registered
alu_data2  out  WIDTH  to alu data2, registered
alu_sel  out  2  to alu sel, registered
alu_out  in  WIDTH  from alu out

Behaviour:
- States: IDLE, EXEC, DONE. Encoding is 2-bit binary: IDLE=0, EXEC=1, DONE=2.
- Reset (sync, rst=1 at a clk edge):
  - State goes to IDLE.
  - grant, done, result, busy, alu_data1, alu_data2 and alu_sel all go to 0.
  - The round-robin pointer goes to 0, so requester 0 has highest priority.
- IDLE:
  - If req != 0, the winner is the first set req bit searching from ptr upward, wrapping modulo NREQ.
  - At that edge: grant = onehot(winner); alu_data1/alu_data2/alu_sel are loaded from the winner's slices; state goes to EXEC.
  - If req == 0, the state stays IDLE and all registers hold.
- EXEC: alu inputs stay stable for the whole cycle. At the edge, result <= alu_out, done <= grant, and state goes to DONE.
- DONE:
  - done is high for exactly this cycle and busy stays high.
  - At the edge: ptr <= (winner+1) mod NREQ, grant <= 0, done <= 0, state goes to IDLE.
  - alu_* registers hold their last values; they are not cleared.
- Latency: req sampled in IDLE at cycle 0 -> done and result valid in cycle 2. Throughput is one operation per 3 cycles.
- Back-to-back: a requester that keeps req high after done is eligible again in the next IDLE, but ranks last behind all other requesters.
- Fairness: with all req bits held high, grants rotate 0,1,..,NREQ-1,0,...
- req or operand changes during EXEC/DONE are ignored. The operation in flight completes and done still pulses for the latched winner.
- Simultaneous rst and any event: reset wins. No done pulse is emitted for an operation aborted by reset.
- Arithmetic: the block performs none. The alu_out -> result path is a straight WIDTH-bit register with no truncation or extension.
- No combinational path from any input to any output.

Decomposition:
- Shared package alu_pkg:
  - ALU_SEL_W = 2
  - ALU_WIDTH = 32
  - arbiter state constants ST_IDLE, ST_EXEC, ST_DONE
- One sub-module, rr_picker: combinational round-robin priority picker.
  - Inputs: req[NREQ], ptr[clog2(NREQ)].
  - Outputs: onehot[NREQ], idx, any.

Test Plan:
(Bench alu stub: alu_out = alu_data1 + alu_data2 + alu_sel.)
1. Reset: hold rst for 2 cycles with random req -> grant=0, done=0, result=0, busy=0, alu_*=0.
2. Single request: req=01, data1[0]=5, data2[0]=3, sel[0]=01 at cycle 0 -> grant=01 in cycles 1-2; alu_sel=01 in cycle 1; done=01 and result=9 in cycle 2; busy low in cycle 3.
3. Both requesters held from reset, distinct operands -> done sequence 01,10,01,10 at cycles 2,5,8,11, with results matching each requester's operands.
4. req[1] alone; drop req[1] and change data1[1] during EXEC -> done=10 still pulses, result uses the latched operands.
5. rst asserted in EXEC -> no done pulse, all outputs 0 next cycle. Then both requesters request -> requester 0 is granted first.
6. req=01 held continuously alone -> done[0] pulses every 3 cycles; a 10 request arriving mid-operation is served in the very next grant.
